// File: rtl/dpipe.sv
// dpipe: two-entry skid buffer between fetch and decode; instructions are
// predecoded on entry so decode sees opcode class, immediate and system info.
module dpipe (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush_i,
    input  logic        f_valid_i,
    output logic        f_ready_o,
    input  logic [63:0] pc_i,
    input  logic [31:0] inst_i,
    output logic        d_valid_o,
    input  logic        d_ready_i,
    output logic [63:0] pc_o,
    output logic [31:0] inst_o,
    output logic [11:0] opinfo_o,
    output logic [63:0] imm_o,
    output logic [4:0]  sys_info_o,
    output logic        illegal_o
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} cnt_t;
    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
        logic [11:0] opinfo;
        logic [63:0] imm;
        logic [4:0]  sys_info;
        logic        illegal;
    } entry_t;

    cnt_t       cnt, cnt_nx;
    logic       rd_ptr, wr_ptr, push, pop;
    entry_t     mem [2];
    entry_t     dec, head;
    logic [6:0] op;
    logic [2:0] f3;
    logic [11:0] cls;

    assign op  = inst_i[6:0];
    assign f3  = inst_i[14:12];
    // bit order: alu, alui, aluw, aluiw, branch, jal, jalr, load, store, lui, auipc, sys
    assign cls = {op == 7'b1110011, op == 7'b0010111, op == 7'b0110111, op == 7'b0100011,
                  op == 7'b0000011, op == 7'b1100111, op == 7'b1101111, op == 7'b1100011,
                  op == 7'b0011011, op == 7'b0111011, op == 7'b0010011, op == 7'b0110011};

    always_comb begin
        dec.pc       = pc_i;
        dec.inst     = inst_i;
        dec.opinfo   = cls;
        dec.illegal  = ~|cls;
        dec.imm      = (cls[1] | cls[3] | cls[6] | cls[7]) ? {{52{inst_i[31]}}, inst_i[31:20]} :
                       cls[8]  ? {{52{inst_i[31]}}, inst_i[31:25], inst_i[11:7]} :
                       cls[4]  ? {{52{inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0} :
                       (cls[9] | cls[10]) ? {{32{inst_i[31]}}, inst_i[31:12], 12'd0} :
                       cls[5]  ? {{44{inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0} :
                       cls[11] ? {52'd0, inst_i[31:20]} : 64'd0;
        dec.sys_info = {cls[11] & (f3 == 3'b010), cls[11] & (f3 == 3'b001),
                        inst_i == 32'h30200073, inst_i == 32'h00000073, inst_i == 32'h00100073};
    end

    assign push = f_valid_i & f_ready_o & ~flush_i;
    assign pop  = d_valid_o & d_ready_i & ~flush_i;

    always_comb begin
        cnt_nx = flush_i         ? EMPTY :
                 (push & ~pop)   ? ((cnt == EMPTY) ? ONE : FULL) :
                 (pop & ~push)   ? ((cnt == FULL) ? ONE : EMPTY) : cnt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= EMPTY;
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
            f_ready_o <= 1'b0;
            mem[0]    <= '0;
            mem[1]    <= '0;
        end else begin
            cnt       <= cnt_nx;
            f_ready_o <= cnt_nx != FULL;
            if (flush_i) begin
                rd_ptr <= 1'b0;
                wr_ptr <= 1'b0;
            end else begin
                if (push) begin
                    mem[wr_ptr] <= dec;
                    wr_ptr      <= ~wr_ptr;
                end
                if (pop) rd_ptr <= ~rd_ptr;
            end
        end
    end

    assign head       = mem[rd_ptr];
    assign d_valid_o  = cnt != EMPTY;
    assign pc_o       = head.pc;
    assign inst_o     = head.inst;
    assign opinfo_o   = head.opinfo;
    assign imm_o      = head.imm;
    assign sys_info_o = head.sys_info;
    assign illegal_o  = head.illegal;
endmodule
